// File: rtl/cia.sv
// Shared CIA register types plus the TOD access-sequencer enums and register addresses.
package cia;

    typedef logic [3:0]  reg4_t;
    typedef logic [7:0]  reg8_t;
    typedef logic [31:0] tod_t;   // lane n (0=10ths..3=hr) at [(3-n)*8 +: 8]

    typedef enum logic [1:0] {
        TOD_OP_SET   = 2'd0,
        TOD_OP_ALARM = 2'd1,
        TOD_OP_GET   = 2'd2
    } tod_op_t;

    typedef enum logic [1:0] {
        TOD_ERR_OK       = 2'd0,
        TOD_ERR_CONFLICT = 2'd1,
        TOD_ERR_TIMEOUT  = 2'd2
    } tod_err_t;

    localparam reg4_t TOD_ADDR_10THS = 4'h8;
    localparam reg4_t TOD_ADDR_SEC   = 4'h9;
    localparam reg4_t TOD_ADDR_MIN   = 4'hA;
    localparam reg4_t TOD_ADDR_HR    = 4'hB;

    function automatic int unsigned tod_lane_lsb(logic [1:0] n);
        return 32'(2'd3 - n) << 3;
    endfunction

endpackage

// File: rtl/cia_tod_seq.sv
// Atomic whole-clock TOD access sequencer sharing the TOD register port with the CPU bus.
// Optional slot-wait timeout is enabled by defining CIA_TOD_SEQ_TIMEOUT_EN.
module cia_tod_seq #(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        res_n,
    input  logic        phi2_dn,
    input  logic        cpu_rd,
    input  logic        cpu_we,
    input  logic [3:0]  cpu_addr,
    input  logic [7:0]  cpu_data,
    input  logic        w_alarm_in,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [31:0] req_tod,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_tod,
    output logic [1:0]  rsp_err,
    output logic        tod_rd,
    output logic        tod_we,
    output logic [3:0]  tod_addr,
    output logic [7:0]  tod_data,
    output logic        tod_w_alarm,
    input  logic [31:0] tod_regs
);
    import cia::*;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_RSP  = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] idx_q, idx_d;
    tod_op_t    op_q, op_d;
    tod_t       req_tod_q, req_tod_d;
    tod_t       rsp_tod_q, rsp_tod_d;
    tod_err_t   err_q, err_d;
    logic       ready_q, ready_d;
    logic       rsp_valid_q, rsp_valid_d;

    logic cpu_busy, slot, cpu_hit;

`ifdef CIA_TOD_SEQ_TIMEOUT_EN
    localparam logic [7:0] WAIT_LIM = (TIMEOUT_CYC > 255) ? 8'd255 : 8'(TIMEOUT_CYC);
    logic [7:0] wait_q, wait_d;
`endif

    assign cpu_busy = cpu_rd | cpu_we;
    assign slot     = phi2_dn & ~cpu_busy;
    assign cpu_hit  = cpu_busy & (cpu_addr >= TOD_ADDR_10THS) & (cpu_addr <= TOD_ADDR_HR);

    // NOTE: every next-state signal gets its hold value first so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        op_d      = op_q;
        req_tod_d = req_tod_q;
        rsp_tod_d = rsp_tod_q;
        err_d     = err_q;
`ifdef CIA_TOD_SEQ_TIMEOUT_EN
        wait_d    = wait_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req_valid && ready_q) begin
                    op_d      = tod_op_t'(req_op);
                    req_tod_d = req_tod;
                    rsp_tod_d = '0;
                    idx_d     = 2'd3;
                    err_d     = TOD_ERR_OK;
`ifdef CIA_TOD_SEQ_TIMEOUT_EN
                    wait_d    = '0;
`endif
                    state_d   = ST_ACC;
                end
            end
            ST_ACC: begin
                if (cpu_hit) err_d = TOD_ERR_CONFLICT;
                if (slot) begin
                    if (op_q == TOD_OP_GET)
                        rsp_tod_d[tod_lane_lsb(idx_q) +: 8] = tod_regs[tod_lane_lsb(idx_q) +: 8];
`ifdef CIA_TOD_SEQ_TIMEOUT_EN
                    wait_d = '0;
`endif
                    if (idx_q == 2'd0) state_d = ST_RSP;
                    else               idx_d   = idx_q - 2'd1;
                end
`ifdef CIA_TOD_SEQ_TIMEOUT_EN
                else if (phi2_dn) begin
                    wait_d = (wait_q == WAIT_LIM) ? wait_q : wait_q + 8'd1;
                    // A timeout abandons the snapshot and wins over any conflict seen so far.
                    if (wait_d == WAIT_LIM) begin
                        state_d   = ST_RSP;
                        err_d     = TOD_ERR_TIMEOUT;
                        rsp_tod_d = '0;
                    end
                end
`endif
            end
            ST_RSP: begin
                if (rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        ready_d     = (state_d == ST_IDLE);
        rsp_valid_d = (state_d == ST_RSP);
    end

    // NOTE: state registers use non-blocking assignments; reset is synchronous, so it sits inside the clocked block.
    always_ff @(posedge clk) begin
        if (!res_n) begin
            state_q     <= ST_IDLE;
            idx_q       <= 2'd3;
            op_q        <= TOD_OP_SET;
            req_tod_q   <= '0;
            rsp_tod_q   <= '0;
            err_q       <= TOD_ERR_OK;
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
`ifdef CIA_TOD_SEQ_TIMEOUT_EN
            wait_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            op_q        <= op_d;
            req_tod_q   <= req_tod_d;
            rsp_tod_q   <= rsp_tod_d;
            err_q       <= err_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
`ifdef CIA_TOD_SEQ_TIMEOUT_EN
            wait_q      <= wait_d;
`endif
        end
    end

    assign req_ready = ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_tod   = rsp_tod_q;
    assign rsp_err   = err_q;

    // The CPU owns the port whenever it accesses any register; GET keeps alarm-select low to read the clock.
    always_comb begin
        tod_rd      = cpu_rd;
        tod_we      = cpu_we;
        tod_addr    = cpu_addr;
        tod_data    = cpu_data;
        tod_w_alarm = w_alarm_in;
        if (state_q == ST_ACC && !cpu_busy) begin
            tod_rd      = (op_q == TOD_OP_GET);
            tod_we      = (op_q != TOD_OP_GET);
            tod_addr    = TOD_ADDR_10THS + {2'b00, idx_q};
            tod_data    = req_tod_q[tod_lane_lsb(idx_q) +: 8];
            tod_w_alarm = (op_q == TOD_OP_ALARM);
        end
    end

endmodule

// File: tb/tb_cia_tod_seq.sv
// Directed bench for cia_tod_seq with a behavioural 6526 TOD register model on the shared port.
module tb_cia_tod_seq;
    import cia::*;

    logic        clk = 1'b0;
    logic        res_n, phi2_dn, cpu_rd, cpu_we, w_alarm_in;
    logic [3:0]  cpu_addr;
    logic [7:0]  cpu_data;
    logic        req_valid, req_ready, rsp_valid, rsp_ready;
    logic [1:0]  req_op, rsp_err;
    logic [31:0] req_tod, rsp_tod, tod_regs;
    logic        tod_rd, tod_we, tod_w_alarm;
    logic [3:0]  tod_addr;
    logic [7:0]  tod_data;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // TOD block model: live clock, alarm, read latch, write-stop
    logic [31:0] live = '0, alarm = '0, latch = '0;
    logic        latched = 1'b0, stopped = 1'b0;
    assign tod_regs = latched ? latch : live;

    logic [3:0] seq_addr[$];
    logic [7:0] seq_data[$];
    logic       seq_rd[$], seq_we[$], seq_wa[$];
    int         cpu_slots, cpu_pass_err;

    always #5 clk = ~clk;

    cia_tod_seq #(.TIMEOUT_CYC(4)) dut (
        .clk(clk), .res_n(res_n), .phi2_dn(phi2_dn), .cpu_rd(cpu_rd), .cpu_we(cpu_we),
        .cpu_addr(cpu_addr), .cpu_data(cpu_data), .w_alarm_in(w_alarm_in),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_tod(req_tod),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_tod(rsp_tod), .rsp_err(rsp_err),
        .tod_rd(tod_rd), .tod_we(tod_we), .tod_addr(tod_addr), .tod_data(tod_data),
        .tod_w_alarm(tod_w_alarm), .tod_regs(tod_regs)
    );

    task automatic tod_access(input logic rd, input logic we, input logic wa,
                              input logic [3:0] addr, input logic [7:0] data);
        int lsb;
        if (addr < 4'h8 || addr > 4'hB) return;
        lsb = (3 - (int'(addr) - 8)) * 8;
        if (we) begin
            if (wa) alarm[lsb +: 8] = data;
            else begin
                live[lsb +: 8] = data;
                if (addr == 4'hB) stopped = 1'b1;
                if (addr == 4'h8) stopped = 1'b0;
            end
        end
        if (rd) begin
            if (addr == 4'hB && !latched) begin
                latched = 1'b1;
                latch   = live;
            end
            if (addr == 4'h8) latched = 1'b0;
        end
    endtask

    task automatic tick10();
        if (stopped) return;
        if (live[31:24] == 8'h09) begin
            live[31:24] = 8'h00;
            live[23:16] = live[23:16] + 8'h01;
        end else live[31:24] = live[31:24] + 8'h01;
    endtask

    task automatic clear_log();
        seq_addr.delete(); seq_data.delete(); seq_rd.delete(); seq_we.delete(); seq_wa.delete();
        cpu_slots = 0; cpu_pass_err = 0;
    endtask

    // One PHI2 cycle (2 clk): strobe clk with optional CPU access, then one idle clk.
    task automatic phi2_cycle(input logic c_rd, input logic c_we,
                              input logic [3:0] c_addr, input logic [7:0] c_data);
        logic s_rd, s_we, s_wa;
        logic [3:0] s_addr;
        logic [7:0] s_data;
        @(negedge clk);
        phi2_dn = 1'b1; cpu_rd = c_rd; cpu_we = c_we; cpu_addr = c_addr; cpu_data = c_data;
        #1;
        s_rd = tod_rd; s_we = tod_we; s_wa = tod_w_alarm; s_addr = tod_addr; s_data = tod_data;
        if (!c_rd && !c_we && (s_rd || s_we)) begin
            seq_addr.push_back(s_addr); seq_data.push_back(s_data);
            seq_rd.push_back(s_rd); seq_we.push_back(s_we); seq_wa.push_back(s_wa);
        end
        if (c_rd || c_we) begin
            cpu_slots++;
            if (s_addr !== c_addr || s_rd !== c_rd || s_we !== c_we || s_data !== c_data ||
                s_wa !== w_alarm_in) cpu_pass_err++;
        end
        @(posedge clk); #1;
        phi2_dn = 1'b0; cpu_rd = 1'b0; cpu_we = 1'b0; cpu_addr = 4'h0; cpu_data = 8'h00;
        tod_access(s_rd, s_we, s_wa, s_addr, s_data);
        @(posedge clk); #1;
    endtask

    task automatic pack_log(output logic [15:0] addrs, output logic [31:0] datas,
                            output logic [3:0] rds, output logic [3:0] wes, output logic [3:0] was);
        addrs = '0; datas = '0; rds = '0; wes = '0; was = '0;
        for (int i = 0; i < 4; i++) begin
            if (i < seq_addr.size()) begin
                addrs = {addrs[11:0], seq_addr[i]};
                datas = {datas[23:0], seq_data[i]};
                rds   = {rds[2:0], seq_rd[i]};
                wes   = {wes[2:0], seq_we[i]};
                was   = {was[2:0], seq_wa[i]};
            end
        end
    endtask

    task automatic do_req(input logic [1:0] op, input logic [31:0] val);
        int k = 0;
        while (req_ready !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        total_cnt++;
        if (req_ready !== 1'b1) $display("FAIL req_ready_wait: req_ready=%b required 1", req_ready);
        else pass_cnt++;
        @(negedge clk);
        req_valid = 1'b1; req_op = op; req_tod = val;
        @(posedge clk); #1;
        req_valid = 1'b0;
        clear_log();
    endtask

    task automatic do_rsp(input string name);
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        total_cnt++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1)
            $display("FAIL %s_handshake: rsp_valid=%b req_ready=%b required 0/1", name, rsp_valid, req_ready);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        res_n = 1'b0; req_valid = 1'b1;
        cpu_we = 1'b1; cpu_addr = 4'h5; cpu_data = 8'hAA; w_alarm_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total_cnt++;
        if ({req_ready, rsp_valid, rsp_tod, rsp_err} !== 36'h0)
            $display("FAIL reset_outputs: ready=%b valid=%b tod=%h err=%0d required all 0",
                     req_ready, rsp_valid, rsp_tod, rsp_err);
        else pass_cnt++;
        total_cnt++;
        if ({tod_rd, tod_we, tod_addr, tod_data, tod_w_alarm} !== {1'b0, 1'b1, 4'h5, 8'hAA, 1'b1})
            $display("FAIL reset_passthru: rd=%b we=%b addr=%h data=%h wa=%b required 0 1 5 aa 1",
                     tod_rd, tod_we, tod_addr, tod_data, tod_w_alarm);
        else pass_cnt++;
        @(negedge clk);
        req_valid = 1'b0; cpu_we = 1'b0; cpu_addr = 4'h0; cpu_data = 8'h00; w_alarm_in = 1'b0;
        res_n = 1'b1;
        @(posedge clk); #1;
        total_cnt++;
        if (req_ready !== 1'b1) $display("FAIL reset_release_ready: got %b required 1", req_ready);
        else pass_cnt++;
    endtask

    task automatic test_set();
        logic [15:0] a; logic [31:0] d; logic [3:0] r, w, wa;
        int early = 0;
        do_req(TOD_OP_SET, 32'h0000_0091);
        for (int i = 0; i < 4; i++) begin
            phi2_cycle(1'b0, 1'b0, 4'h0, 8'h00);
            if (i < 3 && rsp_valid !== 1'b0) early++;
        end
        pack_log(a, d, r, w, wa);
        total_cnt++;
        if (early != 0 || rsp_valid !== 1'b1)
            $display("FAIL set_latency: early=%0d rsp_valid=%b required 0/1", early, rsp_valid);
        else pass_cnt++;
        total_cnt++;
        if (seq_addr.size() != 4 || a !== 16'hBA98 || d !== 32'h9100_0000 || w !== 4'hF || r !== 4'h0 || wa !== 4'h0)
            $display("FAIL set_writes: n=%0d addr=%h data=%h we=%h rd=%h wa=%h required 4 ba98 91000000 f 0 0",
                     seq_addr.size(), a, d, w, r, wa);
        else pass_cnt++;
        total_cnt++;
        if (rsp_err !== TOD_ERR_OK || rsp_tod !== 32'h0 || live !== 32'h0000_0091 || stopped !== 1'b0)
            $display("FAIL set_result: err=%0d tod=%h clock=%h stopped=%b required 0 0 00000091 0",
                     rsp_err, rsp_tod, live, stopped);
        else pass_cnt++;
        do_rsp("set");
    endtask

    task automatic test_get_tick();
        logic [15:0] a; logic [31:0] d; logic [3:0] r, w, wa;
        do_req(TOD_OP_SET, 32'h0905_3002);
        repeat (4) phi2_cycle(1'b0, 1'b0, 4'h0, 8'h00);
        do_rsp("get_preset");
        do_req(TOD_OP_GET, 32'hFFFF_FFFF);
        phi2_cycle(1'b0, 1'b0, 4'h0, 8'h00);
        tick10();
        repeat (3) phi2_cycle(1'b0, 1'b0, 4'h0, 8'h00);
        pack_log(a, d, r, w, wa);
        total_cnt++;
        if (rsp_valid !== 1'b1 || rsp_tod !== 32'h0905_3002 || rsp_err !== TOD_ERR_OK)
            $display("FAIL get_snapshot: valid=%b tod=%h err=%0d required 1 09053002 0", rsp_valid, rsp_tod, rsp_err);
        else pass_cnt++;
        total_cnt++;
        if (a !== 16'hBA98 || r !== 4'hF || w !== 4'h0 || wa !== 4'h0)
            $display("FAIL get_reads: addr=%h rd=%h we=%h wa=%h required ba98 f 0 0", a, r, w, wa);
        else pass_cnt++;
        total_cnt++;
        if (latched !== 1'b0 || tod_regs !== 32'h0006_3002)
            $display("FAIL get_unlatch: latched=%b regs=%h required 0 00063002", latched, tod_regs);
        else pass_cnt++;
        do_rsp("get");
    endtask

    task automatic test_cpu_interleave();
        logic [15:0] a; logic [31:0] d; logic [3:0] r, w, wa;
        int n = 0;
        do_req(TOD_OP_GET, 32'h0);
        while (rsp_valid !== 1'b1 && n < 16) begin
            phi2_cycle(n % 2 == 0, 1'b0, 4'h0, 8'h00);
            n++;
        end
        pack_log(a, d, r, w, wa);
        total_cnt++;
        if (n != 8 || cpu_slots != 4 || cpu_pass_err != 0)
            $display("FAIL interleave_timing: phi2=%0d cpu_slots=%0d pass_err=%0d required 8 4 0", n, cpu_slots, cpu_pass_err);
        else pass_cnt++;
        total_cnt++;
        if (rsp_tod !== 32'h0006_3002 || rsp_err !== TOD_ERR_OK || a !== 16'hBA98)
            $display("FAIL interleave_result: tod=%h err=%0d addr=%h required 00063002 0 ba98", rsp_tod, rsp_err, a);
        else pass_cnt++;
        do_rsp("interleave");
    endtask

    task automatic test_conflict();
        logic [15:0] a; logic [31:0] d; logic [3:0] r, w, wa;
        do_req(TOD_OP_SET, 32'h0000_4501);
        phi2_cycle(1'b0, 1'b0, 4'h0, 8'h00);
        phi2_cycle(1'b0, 1'b0, 4'h0, 8'h00);
        phi2_cycle(1'b0, 1'b1, 4'h8, 8'h07);
        phi2_cycle(1'b0, 1'b0, 4'h0, 8'h00);
        total_cnt++;
        if (rsp_valid !== 1'b0) $display("FAIL conflict_early: rsp_valid=%b required 0", rsp_valid);
        else pass_cnt++;
        phi2_cycle(1'b0, 1'b0, 4'h0, 8'h00);
        pack_log(a, d, r, w, wa);
        total_cnt++;
        if (rsp_valid !== 1'b1 || rsp_err !== TOD_ERR_CONFLICT || rsp_tod !== 32'h0)
            $display("FAIL conflict_err: valid=%b err=%0d tod=%h required 1 1 0", rsp_valid, rsp_err, rsp_tod);
        else pass_cnt++;
        total_cnt++;
        if (seq_addr.size() != 4 || a !== 16'hBA98 || d !== 32'h0145_0000 || w !== 4'hF || live !== 32'h0000_4501)
            $display("FAIL conflict_writes: n=%0d addr=%h data=%h we=%h clock=%h required 4 ba98 01450000 f 00004501",
                     seq_addr.size(), a, d, w, live);
        else pass_cnt++;
        do_rsp("conflict");
    endtask

    task automatic test_alarm();
        logic [15:0] a; logic [31:0] d; logic [3:0] r, w, wa;
        w_alarm_in = 1'b0;
        @(negedge clk); #1;
        total_cnt++;
        if (tod_w_alarm !== 1'b0) $display("FAIL alarm_idle_sel: got %b required 0", tod_w_alarm);
        else pass_cnt++;
        do_req(TOD_OP_ALARM, 32'h0030_1512);
        phi2_cycle(1'b0, 1'b0, 4'h0, 8'h00);
        phi2_cycle(1'b1, 1'b0, 4'h0, 8'h00);
        repeat (3) phi2_cycle(1'b0, 1'b0, 4'h0, 8'h00);
        pack_log(a, d, r, w, wa);
        total_cnt++;
        if (wa !== 4'hF || w !== 4'hF || a !== 16'hBA98 || cpu_slots != 1 || cpu_pass_err != 0)
            $display("FAIL alarm_slots: wa=%h we=%h addr=%h cpu_slots=%0d pass_err=%0d required f f ba98 1 0",
                     wa, w, a, cpu_slots, cpu_pass_err);
        else pass_cnt++;
        total_cnt++;
        if (alarm !== 32'h0030_1512 || live !== 32'h0000_4501 || stopped !== 1'b0 ||
            rsp_valid !== 1'b1 || rsp_err !== TOD_ERR_OK)
            $display("FAIL alarm_result: alarm=%h clock=%h stopped=%b valid=%b err=%0d required 00301512 00004501 0 1 0",
                     alarm, live, stopped, rsp_valid, rsp_err);
        else pass_cnt++;
        do_rsp("alarm");
    endtask

    task automatic test_timeout_reset();
`ifdef CIA_TOD_SEQ_TIMEOUT_EN
        do_req(TOD_OP_GET, 32'h0);
        repeat (3) phi2_cycle(1'b1, 1'b0, 4'h9, 8'h00);
        total_cnt++;
        if (rsp_valid !== 1'b0) $display("FAIL timeout_early: rsp_valid=%b required 0", rsp_valid);
        else pass_cnt++;
        phi2_cycle(1'b1, 1'b0, 4'h9, 8'h00);
        total_cnt++;
        if (rsp_valid !== 1'b1 || rsp_err !== TOD_ERR_TIMEOUT || rsp_tod !== 32'h0)
            $display("FAIL timeout_err: valid=%b err=%0d tod=%h required 1 2 0", rsp_valid, rsp_err, rsp_tod);
        else pass_cnt++;
        do_rsp("timeout");
`endif
        do_req(TOD_OP_SET, 32'h1122_3344);
        repeat (2) phi2_cycle(1'b0, 1'b0, 4'h0, 8'h00);
        @(negedge clk);
        res_n = 1'b0;
        @(posedge clk); #1;
        total_cnt++;
        if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || tod_we !== 1'b0 || tod_rd !== 1'b0)
            $display("FAIL midacc_reset: ready=%b valid=%b we=%b rd=%b required 0 0 0 0",
                     req_ready, rsp_valid, tod_we, tod_rd);
        else pass_cnt++;
        @(negedge clk);
        res_n = 1'b1;
        @(posedge clk); #1;
        total_cnt++;
        if (req_ready !== 1'b1) $display("FAIL midacc_ready: got %b required 1", req_ready);
        else pass_cnt++;
        clear_log();
        repeat (3) phi2_cycle(1'b0, 1'b0, 4'h0, 8'h00);
        total_cnt++;
        if (rsp_valid !== 1'b0 || seq_addr.size() != 0)
            $display("FAIL midacc_dropped: rsp_valid=%b seq_accesses=%0d required 0 0", rsp_valid, seq_addr.size());
        else pass_cnt++;
    endtask

    initial begin
        res_n = 1'b0; phi2_dn = 1'b0; cpu_rd = 1'b0; cpu_we = 1'b0; cpu_addr = 4'h0; cpu_data = 8'h00;
        w_alarm_in = 1'b0; req_valid = 1'b0; req_op = 2'd0; req_tod = '0; rsp_ready = 1'b0;
        clear_log();
        test_reset();
        test_set();
        test_get_tick();
        test_cpu_interleave();
        test_conflict();
        test_alarm();
        test_timeout_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
